// File: rtl/pcm_ar_envelope.sv
// Attack/sustain/release envelope: scales each unsigned PCM sample by an 8-bit level
// that ramps up while gate is high and ramps down after it falls.
module pcm_ar_envelope #(
    parameter int PCM_W  = 16,
    parameter int ENV_W  = 8,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] release_rate,
    input  logic [PCM_W-1:0]  pcm_in,
    output logic [PCM_W-1:0]  pcm_out,
    output logic [ENV_W-1:0]  env_level,
    output logic [1:0]        env_state
);

    localparam int PRESC_W  = 15;
    localparam int PROD_W   = PCM_W + ENV_W;

    localparam logic [ENV_W-1:0] LEVEL_FULL = {ENV_W{1'b1}};
    localparam logic [ENV_W-1:0] LEVEL_ZERO = {ENV_W{1'b0}};
    localparam logic [ENV_W-1:0] LEVEL_ONE  = {{(ENV_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    env_state_t          state_q, state_d;
    logic [ENV_W-1:0]    level_q, level_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PCM_W-1:0]    pcm_q,   pcm_d;

    logic [RATE_W-1:0]   rate_s;
    logic                ramp_s;
    logic                strobe_s;
    logic [PROD_W-1:0]   product_s;

    // Step period is 2^rate clocks, so the strobe threshold is a mask of rate ones.
    function automatic logic [PRESC_W-1:0] step_limit(input logic [RATE_W-1:0] rate);
        return ~({PRESC_W{1'b1}} << rate);
    endfunction

    // Next-state, level step and prescaler control.
    always_comb begin
        state_d = state_q;
        level_d = level_q;

        if (state_q == ST_RELEASE) begin
            rate_s = release_rate;
        end else begin
            rate_s = attack_rate;
        end

        ramp_s   = (state_q == ST_ATTACK) || (state_q == ST_RELEASE);
        strobe_s = ramp_s && (presc_q >= step_limit(rate_s));

        case (state_q)
            ST_IDLE: begin
                if (gate) begin
                    state_d = ST_ATTACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ATTACK: begin
                // Gate wins over the step: a falling gate never takes the increment.
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (strobe_s) begin
                    if (level_q == LEVEL_FULL) begin
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = level_q + LEVEL_ONE;
                        if (level_q == (LEVEL_FULL - LEVEL_ONE)) begin
                            state_d = ST_SUSTAIN;
                        end else begin
                            state_d = ST_ATTACK;
                        end
                    end
                end else begin
                    state_d = ST_ATTACK;
                end
            end
            ST_SUSTAIN: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_SUSTAIN;
                end
            end
            ST_RELEASE: begin
                if (gate) begin
                    state_d = ST_ATTACK;
                end else if (strobe_s) begin
                    if (level_q == LEVEL_ZERO) begin
                        state_d = ST_IDLE;
                    end else begin
                        level_d = level_q - LEVEL_ONE;
                        if (level_q == LEVEL_ONE) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = LEVEL_ZERO;
            end
        endcase

        if ((state_d != state_q) || !ramp_s || strobe_s) begin
            presc_d = {PRESC_W{1'b0}};
        end else begin
            presc_d = presc_q + 15'd1;
        end
    end

    // Sample scaling uses the level in force before the edge.
    always_comb begin
        product_s = {{ENV_W{1'b0}}, pcm_in} * {{PCM_W{1'b0}}, level_q};
        pcm_d     = product_s[PROD_W-1:ENV_W];
    end

    // State, level, prescaler and output sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= LEVEL_ZERO;
            presc_q <= {PRESC_W{1'b0}};
            pcm_q   <= {PCM_W{1'b0}};
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            presc_q <= presc_d;
            pcm_q   <= pcm_d;
        end
    end

    assign pcm_out   = pcm_q;
    assign env_level = level_q;
    assign env_state = state_q;

endmodule

// File: tb/tb_pcm_ar_envelope.sv
// Self-checking bench for pcm_ar_envelope: directed scenarios then random gate/rate/sample
// traffic, all compared against a cycle model built from the envelope rules.
module tb_pcm_ar_envelope;

    logic        clk;
    logic        rst_n;
    logic        gate;
    logic [3:0]  attack_rate;
    logic [3:0]  release_rate;
    logic [15:0] pcm_in;
    logic [15:0] pcm_out;
    logic [7:0]  env_level;
    logic [1:0]  env_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: 0=IDLE 1=ATTACK 2=SUSTAIN 3=RELEASE
    int m_state, m_level, m_presc, m_pcm;

    pcm_ar_envelope #(.PCM_W(16), .ENV_W(8), .RATE_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .release_rate (release_rate),
        .pcm_in       (pcm_in),
        .pcm_out      (pcm_out),
        .env_level    (env_level),
        .env_state    (env_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_level = 0;
        m_presc = 0;
        m_pcm   = 0;
    endtask

    // One clock of the envelope rules, applied to the inputs present at the edge.
    task automatic model_clock();
        int  period;
        bit  strobe;
        int  ns;
        int  nl;
        m_pcm  = (int'(pcm_in) * m_level) / 256;
        period = 1 << ((m_state == 3) ? int'(release_rate) : int'(attack_rate));
        strobe = (m_state == 1 || m_state == 3) && (m_presc >= period - 1);
        ns = m_state;
        nl = m_level;
        case (m_state)
            0: if (gate) ns = 1;
            1: begin
                if (!gate) ns = 3;
                else if (strobe) begin
                    nl = (m_level < 255) ? m_level + 1 : 255;
                    if (nl == 255) ns = 2;
                end
            end
            2: if (!gate) ns = 3;
            default: begin
                if (gate) ns = 1;
                else if (strobe) begin
                    nl = (m_level > 0) ? m_level - 1 : 0;
                    if (nl == 0) ns = 0;
                end
            end
        endcase
        if (ns != m_state || m_state == 0 || m_state == 2 || strobe) m_presc = 0;
        else m_presc = m_presc + 1;
        m_state = ns;
        m_level = nl;
    endtask

    task automatic check_model();
        chk("pcm_out",   32'(pcm_out),   32'(m_pcm));
        chk("env_level", 32'(env_level), 32'(m_level));
        chk("env_state", 32'(env_state), 32'(m_state));
    endtask

    // Advance one edge, update the model, and compare on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_model();
    endtask

    // Asserts reset in the low phase, away from any edge, and checks it acts at once.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_pcm"},   32'(pcm_out),   32'd0);
        chk({tag, "_level"}, 32'(env_level), 32'd0);
        chk({tag, "_state"}, 32'(env_state), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        gate         = 1'b0;
        attack_rate  = 4'd0;
        release_rate = 4'd0;
        pcm_in       = 16'h0000;
        model_reset();
        #12;
        chk("reset_pcm",   32'(pcm_out),   32'd0);
        chk("reset_level", 32'(env_level), 32'd0);
        chk("reset_state", 32'(env_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset while ramping at level 0x40.
        gate = 1'b1; attack_rate = 4'd0; pcm_in = 16'h8000;
        repeat (65) tick();
        chk("mid_attack_level", 32'(env_level), 32'h40);
        chk("mid_attack_pcm",   32'(pcm_out),   32'h1F80);
        gate = 1'b0;
        async_reset("async_rst");
        repeat (3) tick();
        chk("idle_after_rst", 32'(env_state), 32'd0);

        // Fast attack to full scale.
        gate = 1'b1; attack_rate = 4'd0; pcm_in = 16'hFFFF;
        tick();
        chk("attack_entry_state", 32'(env_state), 32'd1);
        chk("attack_entry_level", 32'(env_level), 32'd0);
        tick();
        chk("attack_first_step", 32'(env_level), 32'd1);
        repeat (254) tick();
        chk("sustain_level", 32'(env_level), 32'd255);
        chk("sustain_state", 32'(env_state), 32'd2);
        chk("pre_full_pcm",  32'(pcm_out),   32'hFDFF);
        tick();
        chk("full_scale_pcm", 32'(pcm_out), 32'hFEFF);

        // Release at rate 2: 255 steps of 4 clocks.
        gate = 1'b0; release_rate = 4'd2;
        tick();
        chk("release_entry", 32'(env_state), 32'd3);
        repeat (1019) tick();
        chk("release_last_level", 32'(env_level), 32'd1);
        tick();
        chk("release_done_level", 32'(env_level), 32'd0);
        chk("release_done_state", 32'(env_state), 32'd0);

        // Attack at rate 3: a step every 8 clocks.
        gate = 1'b1; attack_rate = 4'd3;
        tick();
        repeat (7) tick();
        chk("slow_attack_hold", 32'(env_level), 32'd0);
        tick();
        chk("slow_attack_step1", 32'(env_level), 32'd1);
        repeat (8) tick();
        chk("slow_attack_step2", 32'(env_level), 32'd2);

        // Park at level 128 with a very slow release, then check scaling and latency.
        attack_rate = 4'd0;
        repeat (126) tick();
        chk("level_128", 32'(env_level), 32'd128);
        gate = 1'b0; release_rate = 4'd15; pcm_in = 16'h8000;
        tick();
        tick();
        chk("scale_8000", 32'(pcm_out), 32'h4000);
        pcm_in = 16'h0100;
        tick();
        chk("scale_0100", 32'(pcm_out), 32'h0080);

        // Lowering the attack rate mid-count steps on the very next clock.
        gate = 1'b1; attack_rate = 4'd15;
        tick();
        repeat (5) tick();
        chk("rate15_hold", 32'(env_level), 32'd128);
        attack_rate = 4'd0;
        tick();
        chk("rate_drop_step", 32'(env_level), 32'd129);

        // Retrigger from release at level 100 continues upward.
        gate = 1'b0; release_rate = 4'd0;
        repeat (30) tick();
        chk("release_to_100", 32'(env_level), 32'd100);
        gate = 1'b1;
        tick();
        chk("retrig_state", 32'(env_state), 32'd1);
        chk("retrig_level", 32'(env_level), 32'd100);
        tick();
        chk("retrig_101", 32'(env_level), 32'd101);
        tick();
        chk("retrig_102", 32'(env_level), 32'd102);

        // Gate falls on the clock that would reach full scale.
        repeat (152) tick();
        chk("at_254", 32'(env_level), 32'd254);
        gate = 1'b0;
        tick();
        chk("fall_at_254_state", 32'(env_state), 32'd3);
        chk("fall_at_254_level", 32'(env_level), 32'd254);

        // Gate rises on the clock that would reach zero.
        repeat (253) tick();
        chk("at_1", 32'(env_level), 32'd1);
        gate = 1'b1;
        tick();
        chk("rise_at_1_state", 32'(env_state), 32'd1);
        chk("rise_at_1_level", 32'(env_level), 32'd1);

        // Random traffic.
        for (int i = 0; i < 8000; i++) begin
            pcm_in = 16'($urandom);
            if ($urandom_range(0, 199) == 0) gate = ~gate;
            if ($urandom_range(0, 99) == 0) begin
                attack_rate  = 4'($urandom_range(0, 3));
                release_rate = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 999) == 0) async_reset("rand_rst");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
